// File: rtl/neuron_mac_sequencer.sv
// -----------------------------------------------------------------------------
// neuron_mac_sequencer
//
// Controller for a single neuron. On a start pulse from the HPS it reads
// kernel_size (image, weight) word pairs over two independent Avalon-MM read
// masters. It multiply-accumulates the signed low halfwords of each pair and
// presents the result (optionally ReLU-clamped) with a held done flag.
//
// Parameters
//   WEI_OFFSET  byte offset from base_addr to the first weight word
//   RELU        1: negative final result reads back as 0; 0: signed result as-is
//
// Ports
//   clk_clk          in   1   clock
//   reset_reset_n    in   1   synchronous active-low reset
//   start            in   1   begin an evaluation (accepted in IDLE/DONE only)
//   clear            in   1   abort/acknowledge, back to IDLE (beats start)
//   kernel_size      in   8   number of pairs, 0..255
//   base_addr        in  32   byte address of the first image word
//   done             out  1   result valid, held until clear or accepted start
//   out_neuron       out 32   accumulated (optionally ReLU'd) result
//   addr_img         out 32   address of current/last image fetch
//   addr_wei         out 32   address of current/last weight fetch
//   img_*            Avalon-MM read master for image words (writes tied off)
//   wei_*            Avalon-MM read master for weight words (writes tied off)
// -----------------------------------------------------------------------------
module neuron_mac_sequencer #(
    parameter logic [31:0] WEI_OFFSET = 32'h0001_0000,
    parameter bit          RELU       = 1'b1
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        start,
    input  logic        clear,
    input  logic [7:0]  kernel_size,
    input  logic [31:0] base_addr,
    output logic        done,
    output logic [31:0] out_neuron,
    output logic [31:0] addr_img,
    output logic [31:0] addr_wei,
    output logic        img_read,
    output logic        img_write,
    output logic [31:0] img_address,
    output logic [31:0] img_writedata,
    input  logic [31:0] img_readdata,
    input  logic        img_waitrequest,
    output logic        wei_read,
    output logic        wei_write,
    output logic [31:0] wei_address,
    output logic [31:0] wei_writedata,
    input  logic [31:0] wei_readdata,
    input  logic        wei_waitrequest
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_MAC   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q;
    logic        done_q;
    logic [31:0] out_q;
    logic [31:0] addr_img_q;
    logic [31:0] addr_wei_q;
    logic        img_read_q;
    logic        wei_read_q;
    logic        img_got_q;
    logic        wei_got_q;
    logic [15:0] img_data_q;
    logic [15:0] wei_data_q;
    logic [31:0] acc_q;
    logic [7:0]  count_q;
    logic [7:0]  k_q;

    // A word is taken in the cycle the master is reading and not stalled.
    logic img_cap;
    logic wei_cap;
    logic img_have;
    logic wei_have;

    assign img_cap  = img_read_q && !img_waitrequest;
    assign wei_cap  = wei_read_q && !wei_waitrequest;
    // Counting the capture cycle itself lets FETCH leave as soon as the
    // second word lands instead of one cycle later.
    assign img_have = img_got_q || img_cap;
    assign wei_have = wei_got_q || wei_cap;

    // Sign-extend both halfwords to 32 bits first so the product is formed
    // as a full signed 32-bit value; 16x16 signed always fits exactly.
    logic signed [31:0] img_ext;
    logic signed [31:0] wei_ext;
    logic signed [31:0] product;
    logic        [31:0] acc_d;
    logic        [31:0] relu_d;

    assign img_ext = {{16{img_data_q[15]}}, img_data_q};
    assign wei_ext = {{16{wei_data_q[15]}}, wei_data_q};
    assign product = img_ext * wei_ext;
    assign acc_d   = acc_q + product;
    assign relu_d  = (RELU && acc_q[31]) ? 32'h0 : acc_q;

    // Upper halves of the read data carry no information for the MAC.
    logic unused_readdata;
    assign unused_readdata = ^{img_readdata[31:16], wei_readdata[31:16]};

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            out_q      <= 32'h0;
            addr_img_q <= 32'h0;
            addr_wei_q <= 32'h0;
            img_read_q <= 1'b0;
            wei_read_q <= 1'b0;
            img_got_q  <= 1'b0;
            wei_got_q  <= 1'b0;
            img_data_q <= 16'h0;
            wei_data_q <= 16'h0;
            acc_q      <= 32'h0;
            count_q    <= 8'h0;
            k_q        <= 8'h0;
        end else if (clear) begin
            // Any outstanding read is simply abandoned.
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            acc_q      <= 32'h0;
            count_q    <= 8'h0;
            img_read_q <= 1'b0;
            wei_read_q <= 1'b0;
            img_got_q  <= 1'b0;
            wei_got_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // Result registers refresh every DONE cycle; acc is frozen
                    // there, so the value is stable while done is held.
                    if (state_q == S_DONE) begin
                        done_q <= 1'b1;
                        out_q  <= relu_d;
                    end
                    if (start) begin
                        k_q        <= kernel_size;
                        addr_img_q <= base_addr;
                        addr_wei_q <= base_addr + WEI_OFFSET;
                        acc_q      <= 32'h0;
                        count_q    <= 8'h0;
                        done_q     <= 1'b0;
                        img_got_q  <= 1'b0;
                        wei_got_q  <= 1'b0;
                        if (kernel_size == 8'd0) begin
                            state_q <= S_DONE;
                        end else begin
                            // Reads go up together with FETCH so the first
                            // FETCH cycle already presents a request.
                            state_q    <= S_FETCH;
                            img_read_q <= 1'b1;
                            wei_read_q <= 1'b1;
                        end
                    end
                end

                S_FETCH: begin
                    if (img_cap) begin
                        img_data_q <= img_readdata[15:0];
                        img_read_q <= 1'b0;
                        img_got_q  <= 1'b1;
                    end
                    if (wei_cap) begin
                        wei_data_q <= wei_readdata[15:0];
                        wei_read_q <= 1'b0;
                        wei_got_q  <= 1'b1;
                    end
                    if (img_have && wei_have) begin
                        state_q   <= S_MAC;
                        img_got_q <= 1'b0;
                        wei_got_q <= 1'b0;
                    end
                end

                S_MAC: begin
                    acc_q      <= acc_d;
                    count_q    <= count_q + 8'd1;
                    addr_img_q <= addr_img_q + 32'd4;
                    addr_wei_q <= addr_wei_q + 32'd4;
                    if (count_q + 8'd1 == k_q) begin
                        state_q <= S_DONE;
                    end else begin
                        state_q    <= S_FETCH;
                        img_read_q <= 1'b1;
                        wei_read_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done          = done_q;
    assign out_neuron    = out_q;
    assign addr_img      = addr_img_q;
    assign addr_wei      = addr_wei_q;

    assign img_read      = img_read_q;
    assign img_write     = 1'b0;
    assign img_address   = addr_img_q;
    assign img_writedata = 32'h0;

    assign wei_read      = wei_read_q;
    assign wei_write     = 1'b0;
    assign wei_address   = addr_wei_q;
    assign wei_writedata = 32'h0;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac_sequencer
//
// Two instances share all stimulus: one with ReLU, one without. Image and
// weight memories are plain arrays addressed relative to the run's base.
// The expected result is a straight dot product of the signed low halfwords.
// Wait-state patterns cover none, random, and a fixed 3-cycle image stall.
// -----------------------------------------------------------------------------
module tb_neuron_mac_sequencer;

    localparam logic [31:0] WOFF = 32'h0001_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        clear;
    logic [7:0]  kernel_size;
    logic [31:0] base_addr;
    logic        img_waitrequest;
    logic        wei_waitrequest;

    // instance A: RELU=1, instance B: RELU=0
    logic        a_done, b_done;
    logic [31:0] a_out, b_out;
    logic [31:0] a_addr_img, a_addr_wei, b_addr_img, b_addr_wei;
    logic        a_img_read, a_img_write, a_wei_read, a_wei_write;
    logic        b_img_read, b_img_write, b_wei_read, b_wei_write;
    logic [31:0] a_img_address, a_img_writedata, a_wei_address, a_wei_writedata;
    logic [31:0] b_img_address, b_img_writedata, b_wei_address, b_wei_writedata;
    logic [31:0] a_img_readdata, a_wei_readdata, b_img_readdata, b_wei_readdata;

    logic [31:0] img_mem [256];
    logic [31:0] wei_mem [256];
    logic [31:0] mem_base = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] addr, input logic [31:0] b);
        logic [31:0] d;
        d = addr - b;
        if (d[1:0] != 2'b00 || d >= 32'd1024) return -1;
        return int'(d >> 2);
    endfunction

    assign a_img_readdata = (widx(a_img_address, mem_base) >= 0) ? img_mem[widx(a_img_address, mem_base)] : 32'h0;
    assign a_wei_readdata = (widx(a_wei_address, mem_base + WOFF) >= 0) ? wei_mem[widx(a_wei_address, mem_base + WOFF)] : 32'h0;
    assign b_img_readdata = (widx(b_img_address, mem_base) >= 0) ? img_mem[widx(b_img_address, mem_base)] : 32'h0;
    assign b_wei_readdata = (widx(b_wei_address, mem_base + WOFF) >= 0) ? wei_mem[widx(b_wei_address, mem_base + WOFF)] : 32'h0;

    neuron_mac_sequencer #(.WEI_OFFSET(WOFF), .RELU(1'b1)) dut_relu (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .clear(clear),
        .kernel_size(kernel_size), .base_addr(base_addr),
        .done(a_done), .out_neuron(a_out), .addr_img(a_addr_img), .addr_wei(a_addr_wei),
        .img_read(a_img_read), .img_write(a_img_write), .img_address(a_img_address),
        .img_writedata(a_img_writedata), .img_readdata(a_img_readdata), .img_waitrequest(img_waitrequest),
        .wei_read(a_wei_read), .wei_write(a_wei_write), .wei_address(a_wei_address),
        .wei_writedata(a_wei_writedata), .wei_readdata(a_wei_readdata), .wei_waitrequest(wei_waitrequest)
    );

    neuron_mac_sequencer #(.WEI_OFFSET(WOFF), .RELU(1'b0)) dut_raw (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .clear(clear),
        .kernel_size(kernel_size), .base_addr(base_addr),
        .done(b_done), .out_neuron(b_out), .addr_img(b_addr_img), .addr_wei(b_addr_wei),
        .img_read(b_img_read), .img_write(b_img_write), .img_address(b_img_address),
        .img_writedata(b_img_writedata), .img_readdata(b_img_readdata), .img_waitrequest(img_waitrequest),
        .wei_read(b_wei_read), .wei_write(b_wei_write), .wei_address(b_wei_address),
        .wei_writedata(b_wei_writedata), .wei_readdata(b_wei_readdata), .wei_waitrequest(wei_waitrequest)
    );

    // ---------------- slave responder + bus monitor (negedge) ----------------
    int          wait_mode = 0;    // 0 none, 1 random, 2 image stalls 3 cycles
    int          stall_cnt = 0;
    logic [31:0] img_caps [$];
    logic [31:0] wei_caps [$];
    bit          any_read = 1'b0;
    bit          img_pend = 1'b0, wei_pend = 1'b0;
    logic [31:0] img_pend_addr, wei_pend_addr;

    always @(negedge clk) begin
        if (a_img_read || a_wei_read || b_img_read || b_wei_read) any_read = 1'b1;
        // A stalled request must still be up with the same address.
        if (img_pend) begin
            check("img_hold_read", {31'h0, a_img_read}, 32'h1);
            check("img_hold_addr", a_img_address, img_pend_addr);
        end
        if (wei_pend) begin
            check("wei_hold_read", {31'h0, a_wei_read}, 32'h1);
            check("wei_hold_addr", a_wei_address, wei_pend_addr);
        end
        case (wait_mode)
            1: begin
                img_waitrequest = ($urandom_range(0, 2) == 0);
                wei_waitrequest = ($urandom_range(0, 2) == 0);
            end
            2: begin
                wei_waitrequest = 1'b0;
                if (a_img_read && stall_cnt < 3) begin
                    img_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    img_waitrequest = 1'b0;
                    stall_cnt = 0;
                end
            end
            default: begin
                img_waitrequest = 1'b0;
                wei_waitrequest = 1'b0;
            end
        endcase
        if (rst_n && !clear) begin
            if (a_img_read && !img_waitrequest) img_caps.push_back(a_img_address);
            if (a_wei_read && !wei_waitrequest) wei_caps.push_back(a_wei_address);
        end
        img_pend = rst_n && !clear && a_img_read && img_waitrequest;
        wei_pend = rst_n && !clear && a_wei_read && wei_waitrequest;
        img_pend_addr = a_img_address;
        wei_pend_addr = a_wei_address;
    end

    // ---------------- one evaluation, checked against the dot product --------
    task automatic run(input int k, input logic [31:0] base, input int mode,
                       input bit randfill, input bit mid_start, input string tag);
        int          acc;
        int          cycles;
        logic [31:0] exp_relu;
        logic signed [15:0] x, y;
        if (randfill) begin
            for (int i = 0; i < 256; i++) begin
                img_mem[i] = $urandom;
                wei_mem[i] = $urandom;
            end
        end
        mem_base  = base;
        wait_mode = mode;
        stall_cnt = 0;
        img_caps.delete();
        wei_caps.delete();
        any_read  = 1'b0;
        acc = 0;
        for (int i = 0; i < k; i++) begin
            x = img_mem[i][15:0];
            y = wei_mem[i][15:0];
            acc += int'(x) * int'(y);
        end
        exp_relu = (acc < 0) ? 32'h0 : acc;

        start = 1'b1;
        kernel_size = k[7:0];
        base_addr = base;
        @(posedge clk);
        #1;
        start = 1'b0;
        cycles = 0;
        while (!a_done && cycles < 5000) begin
            if (mid_start && cycles == 1) begin
                start = 1'b1;
                kernel_size = 8'd7;
                base_addr = base + 32'h400;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        start = 1'b0;
        check({tag, "_no_timeout"}, {31'h0, cycles < 5000}, 32'h1);
        if (mode == 0) check({tag, "_latency"}, cycles, 2 * k + 1);
        check({tag, "_done_raw"}, {31'h0, b_done}, 32'h1);
        check({tag, "_out_relu"}, a_out, exp_relu);
        check({tag, "_out_raw"}, b_out, acc);
        check({tag, "_img_caps"}, img_caps.size(), k);
        check({tag, "_wei_caps"}, wei_caps.size(), k);
        for (int i = 0; i < k && i < img_caps.size() && i < wei_caps.size(); i++) begin
            check({tag, "_img_addr"}, img_caps[i], base + 4 * i);
            check({tag, "_wei_addr"}, wei_caps[i], base + WOFF + 4 * i);
        end
        if (k == 0) check({tag, "_no_read"}, {31'h0, any_read}, 32'h0);
        $display("run %s: K=%0d base=%h mode=%0d cycles=%0d out_relu=%h out_raw=%h",
                 tag, k, base, mode, cycles, a_out, b_out);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        kernel_size = 8'd0;
        base_addr = 32'h0;
        img_waitrequest = 1'b0;
        wei_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", {31'h0, a_done}, 32'h0);
        check("rst_out", a_out, 32'h0);
        check("rst_addr_img", a_addr_img, 32'h0);
        check("rst_addr_wei", a_addr_wei, 32'h0);
        check("rst_reads", {30'h0, a_img_read, a_wei_read}, 32'h0);
        check("rst_writes", {30'h0, a_img_write, a_wei_write}, 32'h0);
        $display("reset: done=%b out=%h", a_done, a_out);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed dot product 1*5+2*6+3*7+4*8 = 70, no waits.
        for (int i = 0; i < 4; i++) begin
            img_mem[i] = 32'(i + 1);
            wei_mem[i] = 32'(i + 5);
        end
        run(4, 32'h0000_1000, 0, 1'b0, 1'b0, "k4_directed");
        check("k4_value", a_out, 32'd70);

        // Image master stalled 3 cycles per read.
        run(3, 32'h0000_2000, 2, 1'b1, 1'b0, "k3_img_stall");

        // Negative result: -3*4 + 1*2 = -10.
        img_mem[0] = 32'hFFFF_FFFD;
        wei_mem[0] = 32'd4;
        img_mem[1] = 32'd1;
        wei_mem[1] = 32'd2;
        run(2, 32'h0000_3000, 0, 1'b0, 1'b0, "k2_negative");
        check("k2_relu_zero", a_out, 32'h0);
        check("k2_raw_neg10", b_out, 32'hFFFF_FFF6);

        // Empty kernel.
        run(0, 32'h0000_4000, 0, 1'b1, 1'b0, "k0");

        // Abort in FETCH of a K=8 run, then a clean K=1 run.
        mem_base = 32'h0000_5000;
        wait_mode = 1;
        start = 1'b1;
        kernel_size = 8'd8;
        base_addr = 32'h0000_5000;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_mode = 2;
        repeat (1) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr_fetch_done", {31'h0, a_done}, 32'h0);
        check("clr_fetch_reads", {30'h0, a_img_read, a_wei_read}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("clr_fetch_idle", {30'h0, a_img_read, a_wei_read}, 32'h0);
        $display("clear in FETCH: done=%b reads=%b%b", a_done, a_img_read, a_wei_read);
        run(1, 32'h0000_6000, 0, 1'b1, 1'b0, "k1_after_clear");

        // start pulsed while in MAC must be ignored.
        run(5, 32'h0000_7000, 0, 1'b1, 1'b1, "k5_mid_start");

        // clear in DONE drops done.
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr_done", {31'h0, a_done}, 32'h0);
        $display("clear in DONE: done=%b", a_done);

        // clear beats a simultaneous start.
        clear = 1'b1;
        start = 1'b1;
        kernel_size = 8'd3;
        @(posedge clk);
        #1;
        clear = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("clr_start_reads", {30'h0, a_img_read, a_wei_read}, 32'h0);
        check("clr_start_done", {31'h0, a_done}, 32'h0);
        $display("clear+start: reads=%b%b done=%b", a_img_read, a_wei_read, a_done);

        // Largest kernel, then a randomized batch.
        run(255, 32'h0010_0000, 0, 1'b1, 1'b0, "k255");
        for (int t = 0; t < 12; t++) begin
            run($urandom_range(1, 20), $urandom & 32'hFFFF_FFFC,
                $urandom_range(0, 2), 1'b1, 1'b0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
